serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to add the current a, b and cin.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in for bit 0.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result of the last completed addition.
REQ-011 The block SHALL have port cout, output, 1 bit: carry-out of the last completed addition.

Function
REQ-012 The datapath SHALL be bit-serial: one 1-bit full adder (sum = x^y^c, carry = majority(x,y,c)) plus a 1-bit carry flip-flop, processing one bit per clock, LSB first.
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, start=1 at a rising edge SHALL latch a, b and cin into internal shift and carry registers, clear the bit counter to 0 and go to SHIFT.
REQ-015 In IDLE, start=0 SHALL leave the FSM in IDLE.
REQ-016 In SHIFT, each edge SHALL add operand LSBs with the carry flop, shift the result bit into the MSB of a result shift register, shift both operand registers right, update the carry flop and increment the counter.
REQ-017 SHIFT SHALL last exactly WIDTH edges; the edge that processes bit WIDTH-1 SHALL go to DONE.
REQ-018 The edge entering DONE SHALL load sum from the result shift register and cout from the final carry.
REQ-019 DONE SHALL last one cycle and return to IDLE unconditionally.
REQ-020 Latency: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH; the next start is accepted at edge k+WIDTH+2 at the earliest.
REQ-021 busy SHALL equal 1 exactly while the state is SHIFT.
REQ-022 done SHALL equal 1 exactly while the state is DONE.
REQ-023 start SHALL be ignored in SHIFT and DONE: no operand relatch, no restart, no effect on the result.
REQ-024 a, b and cin SHALL be don't-care except at the accepting edge; changes during SHIFT SHALL not affect the result.
REQ-025 sum and cout SHALL hold their previous values throughout SHIFT and until the next DONE entry, with no partial results visible.
REQ-026 The result SHALL equal (a + b + cin) mod 2^WIDTH, with cout = bit WIDTH of the full sum.
REQ-027 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during an operation.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock, force state=IDLE, counter=0, carry flop=0, all shift registers=0, sum=0, cout=0, busy=0 and done=0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse for it SHALL ever appear.
REQ-030 On the first edge after rst_n deasserts, the block SHALL be in IDLE and able to accept start.

Verification (WIDTH=8)
REQ-031 The bench SHALL run a=8'h3C, b=8'h0F, cin=0, start pulse and check busy=1 for 8 cycles, then done=1 for 1 cycle with sum=8'h4B and cout=0.
REQ-032 The bench SHALL run a=8'hFF, b=8'h01, cin=0 and check sum=8'h00 and cout=1; it SHALL then run a=8'hA5, b=8'h5A, cin=1 and check sum=8'h00 and cout=1.
REQ-033 The bench SHALL run a=8'h00, b=8'h00, cin=1 and check sum=8'h01 and cout=0, with sum holding 8'h00 from the prior result until done.
REQ-034 The bench SHALL start with a=8'h10, b=8'h20, then pulse start with a=8'hFF, b=8'hFF at SHIFT cycle 3, and check that only one done appears, with sum=8'h30 and cout=0.
REQ-035 The bench SHALL assert rst_n=0 at SHIFT cycle 4 of any operation and check that all outputs go to 0 asynchronously and no done follows; after release, a start with a=8'h01, b=8'h01 SHALL give sum=8'h02.
REQ-036 The bench SHALL hold start=1 continuously and check that done pulses every WIDTH+2 cycles and each result matches the operands present at its accepting edge.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder and a carry flop walk the operands LSB first,
// producing a WIDTH-bit sum and carry-out after WIDTH shift cycles.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// SHIFT | one operand bit added per clock, LSB first (busy=1)
// DONE  | single cycle with a fresh sum/cout (done=1), then back to IDLE
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic             carry;
    logic             fa_s, fa_c;
    logic             last_bit;

    assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sum/cout only change on the edge entering DONE, so partial results never show
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_sr  <= {fa_s, r_sr[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= {fa_s, r_sr[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
